// File: rtl/sat_add_pkg.sv
// Shared constants, output-register state type and saturation limits
// for the round-robin shared saturating adder.
package sat_add_pkg;

  localparam int W_DEFAULT     = 4;
  localparam int N_REQ_DEFAULT = 4;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Limits are returned 32 bits wide; callers cast down to their own width.
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_min(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_add_core.sv
// Combinational W-bit two's-complement adder that clamps to the signed
// range on overflow and flags the clamp.
module sat_add_core
  import sat_add_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  localparam logic [W-1:0] MAX_POS = W'(sat_max(W));
  localparam logic [W-1:0] MIN_NEG = W'(sat_min(W));

  logic [W-1:0] s;
  logic         ovf;

  always_comb begin
    s   = a + b;
    // Only like-signed operands can overflow; the wrapped sign then disagrees.
    ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    sat = ovf;
    sum = ovf ? (a[W-1] ? MIN_NEG : MAX_POS) : s;
  end

endmodule

// File: rtl/sat_add_rr_sched.sv
// Round-robin arbiter sharing one saturating adder between N_REQ requesters,
// with a one-entry result register. Define SAT_ADD_RR_STATS_EN for counters.
module sat_add_rr_sched
  import sat_add_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int W     = W_DEFAULT,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_vld,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_rdy,
  output logic               res_vld,
  input  logic               res_rdy,
  output logic [W-1:0]       res_sum,
  output logic [ID_W-1:0]    res_id,
  output logic               res_sat
`ifdef SAT_ADD_RR_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        stat_ops,
  output logic [15:0]        stat_sat
`endif
);

  out_state_t      state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            acc_en;
  logic            accept;
  logic [W-1:0]    a_sel, b_sel;
  logic [W-1:0]    sum;
  logic            sat;

  assign res_vld = (state == OUT_FULL);
  assign acc_en  = ~res_vld | res_rdy;
  assign accept  = |req_rdy;

  // Grant depends only on valids, pointer and downstream ready, never on data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    req_rdy = '0;
    gnt_id  = '0;
    found   = 1'b0;
    idx     = '0;
    if (acc_en) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = ID_W'((int'(ptr) + i) % N_REQ);
        if (!found && req_vld[idx]) begin
          req_rdy[idx] = 1'b1;
          gnt_id       = idx;
          found        = 1'b1;
        end
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_rdy[i]) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  sat_add_core #(.W(W)) u_core (
    .a   (a_sel),
    .b   (b_sel),
    .sum (sum),
    .sat (sat)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (accept)              state_nxt = OUT_FULL;
      OUT_FULL:  if (res_rdy && !accept)  state_nxt = OUT_EMPTY;
      default:                            state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= OUT_EMPTY;
    else     state <= state_nxt;
  end

  // Payload only loads on accept, which keeps it frozen under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum <= '0;
      res_id  <= '0;
      res_sat <= 1'b0;
      ptr     <= '0;
    end else if (accept) begin
      res_sum <= sum;
      res_id  <= gnt_id;
      res_sat <= sat;
      ptr     <= ID_W'((int'(gnt_id) + 1) % N_REQ);
    end
  end

`ifdef SAT_ADD_RR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops <= '0;
      stat_sat <= '0;
    end else if (stat_clr) begin
      stat_ops <= '0;
      stat_sat <= '0;
    end else if (accept) begin
      if (stat_ops != 16'hFFFF)        stat_ops <= stat_ops + 16'd1;
      if (sat && stat_sat != 16'hFFFF) stat_sat <= stat_sat + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sat_add_rr_sched.sv
// Directed bench for sat_add_rr_sched (N_REQ=4, W=4): vector table plus
// round-robin, backpressure, reset and optional counter sequences.
module tb_sat_add_rr_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_vld = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_rdy;
  logic        res_vld;
  logic        res_rdy = 1'b0;
  logic [3:0]  res_sum;
  logic [1:0]  res_id;
  logic        res_sat;
`ifdef SAT_ADD_RR_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_ops;
  logic [15:0] stat_sat;
`endif

  int errors = 0;
  int checks = 0;

  sat_add_rr_sched #(.N_REQ(4), .W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_a   (req_a),
    .req_b   (req_b),
    .req_rdy (req_rdy),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .res_sum (res_sum),
    .res_id  (res_id),
    .res_sat (res_sat)
`ifdef SAT_ADD_RR_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_ops (stat_ops),
    .stat_sat (stat_sat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] a;
    logic [15:0] b;
    logic        rdy;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [3:0]  exp_sum;
    logic [1:0]  exp_id;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                       input logic r);
    req_vld = v;
    req_a   = a;
    req_b   = b;
    res_rdy = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // requester i occupies bits [i*4 +: 4]
    vecs[0] = '{4'b0001, 16'h0005, 16'h0006, 1'b1, 4'b0001, 1'b1, 4'b0111, 2'd0, 1'b1};
    vecs[1] = '{4'b0010, 16'h00B0, 16'h00A0, 1'b1, 4'b0010, 1'b1, 4'b1000, 2'd1, 1'b1};
    vecs[2] = '{4'b0010, 16'h0030, 16'h0080, 1'b1, 4'b0010, 1'b1, 4'b1011, 2'd1, 1'b0};
    vecs[3] = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[4] = '{4'b0100, 16'h0700, 16'h0100, 1'b1, 4'b0100, 1'b1, 4'b0111, 2'd2, 1'b1};
    vecs[5] = '{4'b1000, 16'h8000, 16'hF000, 1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1};
    vecs[6] = '{4'b1111, 16'h000F, 16'h0001, 1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[7] = '{4'b0001, 16'h0002, 16'h0003, 1'b1, 4'b0001, 1'b1, 4'b0101, 2'd0, 1'b0};
    vecs[8] = '{4'b1000, 16'hC000, 16'hC000, 1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b0};

    // Reset state, asserted from time zero.
    #1;
    check("reset res_vld", 32'(res_vld), 32'd0);
    check("reset res_sum", 32'(res_sum), 32'd0);
    check("reset res_id",  32'(res_id),  32'd0);
    check("reset res_sat", 32'(res_sat), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table vectors: grant checked before the edge, result after it.
    for (int k = 0; k < 9; k++) begin
      apply(vecs[k].vld, vecs[k].a, vecs[k].b, vecs[k].rdy);
      @(negedge clk);
      check($sformatf("vec%0d req_rdy", k), 32'(req_rdy), 32'(vecs[k].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("vec%0d res_vld", k), 32'(res_vld), 32'(vecs[k].exp_vld));
      if (vecs[k].exp_vld) begin
        check($sformatf("vec%0d res_sum", k), 32'(res_sum), 32'(vecs[k].exp_sum));
        check($sformatf("vec%0d res_id", k),  32'(res_id),  32'(vecs[k].exp_id));
        check($sformatf("vec%0d res_sat", k), 32'(res_sat), 32'(vecs[k].exp_sat));
      end
    end

    // Round robin with all requesters valid: lane i adds i + 1.
    for (int k = 0; k < 8; k++) begin
      apply(4'b1111, 16'h3210, 16'h1111, 1'b1);
      @(negedge clk);
      check($sformatf("rr%0d req_rdy", k), 32'(req_rdy), 32'(4'b0001 << (k % 4)));
      @(posedge clk); #1;
      check($sformatf("rr%0d res_id", k),  32'(res_id),  32'(k % 4));
      check($sformatf("rr%0d res_sum", k), 32'(res_sum), 32'((k % 4) + 1));
    end

    // Backpressure: grants blocked and result frozen on id 3 / sum 4.
    for (int k = 0; k < 3; k++) begin
      apply(4'b1111, 16'h3210, 16'h1111, 1'b0);
      @(negedge clk);
      check($sformatf("bp%0d req_rdy", k), 32'(req_rdy), 32'd0);
      @(posedge clk); #1;
      check($sformatf("bp%0d res_vld", k), 32'(res_vld), 32'd1);
      check($sformatf("bp%0d res_sum", k), 32'(res_sum), 32'd4);
      check($sformatf("bp%0d res_id", k),  32'(res_id),  32'd3);
    end
    res_rdy = 1'b1;
    @(negedge clk);
    check("drain req_rdy", 32'(req_rdy), 32'b0001);
    @(posedge clk); #1;
    check("drain res_vld", 32'(res_vld), 32'd1);
    check("drain res_id",  32'(res_id),  32'd0);
    check("drain res_sum", 32'(res_sum), 32'd1);

    // Move ptr to 3, then reset while the result is held.
    apply(4'b0100, 16'h3210, 16'h1111, 1'b1);
    @(negedge clk);
    check("pre-rst req_rdy", 32'(req_rdy), 32'b0100);
    @(posedge clk); #1;
    check("pre-rst res_vld", 32'(res_vld), 32'd1);
    apply(4'b0000, 16'h0000, 16'h0000, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async rst res_vld", 32'(res_vld), 32'd0);
    check("async rst res_sum", 32'(res_sum), 32'd0);
    check("async rst res_id",  32'(res_id),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("post-rst res_vld", 32'(res_vld), 32'd0);
    apply(4'b1100, 16'h3210, 16'h1111, 1'b1);
    @(negedge clk);
    check("post-rst req_rdy", 32'(req_rdy), 32'b0100);
    @(posedge clk); #1;
    check("post-rst res_id",  32'(res_id),  32'd2);
    check("post-rst res_sum", 32'(res_sum), 32'd3);

`ifdef SAT_ADD_RR_STATS_EN
    // Clear, then five accepts on lane 0 of which two saturate.
    apply(4'b0000, 16'h0000, 16'h0000, 1'b1);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat clr ops", 32'(stat_ops), 32'd0);
    apply(4'b0001, 16'h0005, 16'h0006, 1'b1); @(posedge clk); #1;
    apply(4'b0001, 16'h0001, 16'h0001, 1'b1); @(posedge clk); #1;
    apply(4'b0001, 16'h0008, 16'h0008, 1'b1); @(posedge clk); #1;
    apply(4'b0001, 16'h0002, 16'h0002, 1'b1); @(posedge clk); #1;
    apply(4'b0001, 16'h0003, 16'h0000, 1'b1); @(posedge clk); #1;
    apply(4'b0000, 16'h0000, 16'h0000, 1'b1);
    check("stat ops", 32'(stat_ops), 32'd5);
    check("stat sat", 32'(stat_sat), 32'd2);
    apply(4'b0001, 16'h0005, 16'h0006, 1'b1);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    apply(4'b0000, 16'h0000, 16'h0000, 1'b1);
    check("stat clr prio ops", 32'(stat_ops), 32'd0);
    check("stat clr prio sat", 32'(stat_sat), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sat_add_rr_sched.md
Name: sat_add_rr_sched

Overview:
- Shares one signed saturating adder between N requesters using round-robin arbitration.
- Each requester presents an operand pair over a valid/ready handshake.
- The winning pair is added with saturation, and the result is registered with the requester ID and a saturation flag.
- Sits between multiple ALU-lane front ends and a single shared arithmetic resource in the combinational-arithmetic datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 4, operand/result width in bits, two's complement.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_vld  in  N_REQ  per-requester request valid.
- req_a  in  N_REQ*W  packed operand A; requester i occupies bits [i*W +: W].
- req_b  in  N_REQ*W  packed operand B, same packing.
- req_rdy  out  N_REQ  one-hot grant/accept; requester i's pair is consumed when req_vld[i] & req_rdy[i].
- res_vld  out  1  result valid.
- res_rdy  in  1  downstream ready.
- res_sum  out  W  saturated signed sum.
- res_id  out  $clog2(N_REQ)  index of the originating requester.
- res_sat  out  1  1 when the result was clamped.

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous, active-high. On assertion: res_vld=0, res_sum=0, res_id=0, res_sat=0, RR pointer=0, and any held result is discarded.
- Output register states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY when res_rdy=1 and no new accept.
  - FULL → FULL when res_rdy=1 and a new accept happens in the same cycle (back-to-back).
  - FULL → FULL with contents unchanged when res_rdy=0.
- Accept enable: acc_en = ~res_vld | res_rdy. req_rdy is all-zero when acc_en=0.
- Arbitration:
  - When acc_en=1, req_rdy is one-hot on the first asserted req_vld searching from index ptr upward, wrapping modulo N_REQ.
  - req_rdy is all-zero when no request is valid.
  - req_rdy depends combinationally on req_vld, ptr and res_rdy; it must not depend on req_a/req_b.
- Pointer update: on accept from index g, ptr ← (g+1) mod N_REQ. ptr is unchanged when there is no accept. This gives a starvation bound of N_REQ-1 grants.
- Latency: the result appears on res_* the cycle after the accept edge, i.e. 1 cycle. Sustained throughput is 1 result/cycle when res_rdy=1.
- Arithmetic:
  - s = a + b, computed modulo 2^W.
  - Overflow when a[W-1]==b[W-1] and s[W-1]!=a[W-1].
  - On overflow, res_sum = a[W-1] ? 1 followed by W-1 zeros (min negative) : 0 followed by W-1 ones (max positive), and res_sat=1.
  - Otherwise res_sum = s and res_sat=0.
  - Mixed-sign operands never saturate.
- Output stability: res_sum, res_id and res_sat hold stable while res_vld=1 and res_rdy=0.
- Requester behaviour: a requester must not be assumed to hold its data after being granted. Ungranted requests may change freely.
- Reset mid-operation: an in-flight result is dropped, with no partial output after deassertion. The first grant after reset starts at index 0.

Optional Feature:
- Macro: SAT_ADD_RR_STATS_EN.
- When defined:
  - Adds output ports stat_ops (16 bits), stat_sat (16 bits) and input stat_clr (1 bit).
  - stat_ops increments on every accept; stat_sat increments on every accept whose result saturates.
  - Both counters saturate at 16'hFFFF (no wrap).
  - stat_clr zeroes both counters synchronously, taking priority over a same-cycle increment.
  - rst clears both counters.
- When undefined: the ports and logic are absent; the behaviour is otherwise identical.

Decomposition:
- Package sat_add_pkg:
  - W_DEFAULT and N_REQ_DEFAULT constants.
  - typedef enum {OUT_EMPTY, OUT_FULL} out_state_t.
  - Function sat_max(W), function sat_min(W).
- Sub-module sat_add_core:
  - Purely combinational, parameter W.
  - Inputs a, b; outputs sum, sat.
  - Instantiated once on the granted operand pair.
- The round-robin picker stays inline in sat_add_rr_sched.

Test Plan:
- W=4, req0 only, a=0101, b=0110, res_rdy=1 → next cycle res_vld=1, res_sum=0111, res_sat=1, res_id=0.
- req1 only, a=1011, b=1010 → res_sum=1000, res_sat=1. Separately, a=0011, b=1000 → res_sum=1011, res_sat=0.
- All four req_vld held high, res_rdy=1, 8 cycles → res_id sequence 0,1,2,3,0,1,2,3 with req_rdy one-hot each cycle.
- res_rdy=0 for 3 cycles with requests pending → req_rdy=0, res_* frozen. Then res_rdy=1 → the held result drains and the next grant is issued in the same cycle, with no bubble.
- Assert rst while res_vld=1 → res_vld=0 asynchronously. After release, req2 and req3 valid → first grant goes to req2 (ptr=0 search).
- With SAT_ADD_RR_STATS_EN: 5 accepts, 2 of them saturating → stat_ops=5, stat_sat=2. stat_clr pulsed together with an accept → both counters read 0 next cycle.
